iobus_responder: RTL and testbench
==================================

// Module: iobus_responder
// PURPOSE
//  Device-side responder for the CPU's memory-mapped IO bus; the CPU core is the initiator.
//  Decodes IOBUS_ADDR and captures IOBUS_WR writes into registers. Returns read data on IOBUS_IN.
//  Contains a switch input port, an LED output register and a compare timer. The timer drives the CPU's INTR pin.
//  Sits at top level beside the pipelined core; connects directly to its IOBUS_* ports.
// PARAMETERS
//  BASE_ADDR  32'h1100_0000  base of IO window; all offsets below are relative to this
//  SW_WIDTH   16             switch input width, zero-extended to 32 on read
//  LED_WIDTH  16             LED register width
//  PRESCALE   1              timer counts once every PRESCALE CLK cycles (>=1)
// PORTS
//  CLK         in   1          system clock
//  RESET       in   1          synchronous, active-high reset
//  IOBUS_ADDR  in   32         byte address from CPU
//  IOBUS_OUT   in   32         write data from CPU
//  IOBUS_WR    in   1          write strobe, 1 cycle per store
//  IOBUS_IN    out  32         read data to CPU
//  INTR        out  1          level interrupt to CPU
//  SWITCHES    in   SW_WIDTH   asynchronous board switches
//  LEDS        out  LED_WIDTH  LED drive
// BEHAVIOUR
//  Address map (word aligned, addr[1:0] ignored):
//    +0x00 SW  RO | +0x20 LED RW | +0x40 CTRL RW | +0x44 CMP RW | +0x48 CNT RW | +0x4C STAT RW1C
//    Any other address: reads return 0 and writes are ignored. Any address outside the window is likewise a no-op.
//  CTRL bits: [0] EN, [1] AUTORELOAD, [2] IE. Bits [31:3] read as 0. STAT bit [0] PEND.
//  Reset values: IOBUS_IN=0, LEDS=0, CTRL=0, CMP=32'hFFFF_FFFF, CNT=0, PEND=0, INTR=0, prescaler=0.
//  Write: the register updates on the CLK edge where IOBUS_WR=1. The new value is visible to a read issued on the next cycle.
//  Read: IOBUS_IN is registered, giving 1-cycle latency. Data reflects register state at the edge after the address is presented.
//    Reads have no side effects.
//  SWITCHES pass through a 2-flop synchronizer before the read mux. Latency from a switch change to a readable value is 2 cycles.
//  Timer:
//    - The prescaler counts while EN=1. It issues a tick when it reaches PRESCALE-1, then wraps to 0.
//    - On a tick: if CNT==CMP, set PEND. Then CNT<=0 if AUTORELOAD=1; otherwise CNT holds and EN<=0 (one-shot).
//      If CNT!=CMP, CNT<=CNT+1 and wraps mod 2^32.
//    - EN=0 holds CNT and clears the prescaler to 0.
//  INTR = PEND & IE. It is a function of registers only, so it is glitch-free. INTR stays high until PEND is cleared.
//  Writing STAT with bit0=1 clears PEND. Writing bit0=0 has no effect.
//  Simultaneous events:
//    - CPU write to CNT or CTRL on the same edge as a tick: the CPU write wins and no match is evaluated that edge.
//    - STAT W1C on the same edge as a new match: set wins, so PEND stays 1.
//    - Writing CMP equal to the current CNT: the match fires on the next tick.
//  RESET asserted mid-count returns every register to its reset value on that edge. INTR drops the same edge.
// STRUCTURE
//  Package iobus_pkg:
//    - localparam offsets (OFF_SW, OFF_LED, OFF_CTRL, OFF_CMP, OFF_CNT, OFF_STAT)
//    - CTRL bit indices
//    - typedef struct packed {en, autoreload, ie} timer_ctrl_t
//  Sub-module iobus_timer:
//    - Owns the prescaler, CNT, PEND and the one-shot EN clear.
//    - Inputs are the decoded write strobes and data. Outputs are cnt, pend and en_clr.
//  The top level holds the address decode, LED/CTRL/CMP registers, synchronizer and registered read mux.
// TESTING
//  1. RESET 1 cycle -> LEDS=0, INTR=0; a read of CMP returns FFFF_FFFF and a read of CTRL returns 0.
//  2. Write 0xA5A5 to +0x20 -> LEDS=0xA5A5 on the next edge; a read returns 0x0000_A5A5 one cycle later.
//     Write to +0x24 -> no register changes.
//  3. SWITCHES=0x1234 applied asynchronously -> a read of +0x00 returns 0x1234 no earlier than 2 cycles after the change.
//  4. PRESCALE=1, CMP=5, CTRL=0b101 -> INTR rises 6 cycles after EN is written. CNT holds 5 and EN reads 0.
//     W1C STAT -> INTR=0 on the next edge.
//  5. CMP=3, CTRL=0b111 -> PEND sets at each match and CNT returns 0 then 1,2,3.
//     A W1C issued on the exact match edge leaves INTR=1.
//  6. RESET asserted while CNT=2 and EN=1 -> CNT=0, CTRL=0, INTR=0 next edge, and CNT stays 0 afterwards.

Source files
------------

// File: rtl/iobus_pkg.sv
// rtl/iobus_pkg.sv - shared offsets, control bit layout and decode helper for the IO bus responder
package iobus_pkg;

  localparam logic [7:0] OFF_SW   = 8'h00;
  localparam logic [7:0] OFF_LED  = 8'h20;
  localparam logic [7:0] OFF_CTRL = 8'h40;
  localparam logic [7:0] OFF_CMP  = 8'h44;
  localparam logic [7:0] OFF_CNT  = 8'h48;
  localparam logic [7:0] OFF_STAT = 8'h4C;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IE         = 2;
  localparam int STAT_PEND       = 0;

  typedef struct packed {
    logic ie;
    logic autoreload;
    logic en;
  } timer_ctrl_t;

  // Registers are word aligned, so only the word index takes part in decode.
  function automatic logic [5:0] word_idx(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/iobus_responder_if.sv
// rtl/iobus_responder_if.sv - CPU memory-mapped IO bus, core as master, device as slave
interface iobus_responder_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/iobus_timer.sv
// rtl/iobus_timer.sv - prescaled compare timer owning CNT, PEND and the one-shot enable clear
module iobus_timer
  import iobus_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        autoreload,
  input  logic [31:0] cmp,
  input  logic [31:0] wdata,
  input  logic        cnt_we,
  input  logic        ctrl_we,
  input  logic        stat_we,
  output logic [31:0] cnt,
  output logic        pend,
  output logic        en_clr
);

  localparam logic [31:0] PRESC_LAST = 32'(PRESCALE - 1);

  logic [31:0] presc;
  logic        tick;
  logic        cpu_owns;
  logic        match;

  assign tick     = en && (presc == PRESC_LAST);
  // A CPU write to CNT or CTRL on a tick edge suppresses that tick entirely.
  assign cpu_owns = cnt_we || ctrl_we;
  assign match    = tick && !cpu_owns && (cnt == cmp);
  assign en_clr   = match && !autoreload;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      if (!en || tick) presc <= '0;
      else             presc <= presc + 32'd1;

      if (cnt_we) begin
        cnt <= wdata;
      end else if (tick && !ctrl_we) begin
        if (cnt == cmp) begin
          if (autoreload) cnt <= '0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end

      // A new match beats a simultaneous W1C.
      if (match)                           pend <= 1'b1;
      else if (stat_we && wdata[STAT_PEND]) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/iobus_responder.sv
// rtl/iobus_responder.sv - IO bus responder with switch input, LED register and compare timer
module iobus_responder
  import iobus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int          SW_WIDTH  = 16,
  parameter int          LED_WIDTH = 16,
  parameter int          PRESCALE  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  iobus_responder_if.slave     bus,
  output logic                 INTR,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  output logic [LED_WIDTH-1:0] LEDS
);

  logic [31:0]          off;
  logic                 hit;
  logic [5:0]           widx;
  logic                 sel_sw, sel_led, sel_ctrl, sel_cmp, sel_cnt, sel_stat;
  logic                 we_led, we_ctrl, we_cmp, we_cnt, we_stat;
  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  timer_ctrl_t          ctrl;
  logic [31:0]          cmp;
  logic [31:0]          cnt;
  logic                 pend;
  logic                 en_clr;
  logic [31:0]          rd_data;
  logic [31:0]          ctrl_rd;
  logic [31:0]          rd_q;
  logic                 unused_addr_bits;

  assign off              = bus.IOBUS_ADDR - BASE_ADDR;
  assign hit              = (off[31:8] == 24'd0);
  assign widx             = off[7:2];
  assign unused_addr_bits = &{1'b0, off[1:0]};

  assign sel_sw   = hit && (widx == word_idx(OFF_SW));
  assign sel_led  = hit && (widx == word_idx(OFF_LED));
  assign sel_ctrl = hit && (widx == word_idx(OFF_CTRL));
  assign sel_cmp  = hit && (widx == word_idx(OFF_CMP));
  assign sel_cnt  = hit && (widx == word_idx(OFF_CNT));
  assign sel_stat = hit && (widx == word_idx(OFF_STAT));

  assign we_led  = bus.IOBUS_WR && sel_led;
  assign we_ctrl = bus.IOBUS_WR && sel_ctrl;
  assign we_cmp  = bus.IOBUS_WR && sel_cmp;
  assign we_cnt  = bus.IOBUS_WR && sel_cnt;
  assign we_stat = bus.IOBUS_WR && sel_stat;

  iobus_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .en         (ctrl.en),
    .autoreload (ctrl.autoreload),
    .cmp        (cmp),
    .wdata      (bus.IOBUS_OUT),
    .cnt_we     (we_cnt),
    .ctrl_we    (we_ctrl),
    .stat_we    (we_stat),
    .cnt        (cnt),
    .pend       (pend),
    .en_clr     (en_clr)
  );

  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[CTRL_EN]         = ctrl.en;
    ctrl_rd[CTRL_AUTORELOAD] = ctrl.autoreload;
    ctrl_rd[CTRL_IE]         = ctrl.ie;
  end

  always_comb begin
    rd_data = '0;
    if (sel_sw)        rd_data = 32'(sw_s2);
    else if (sel_led)  rd_data = 32'(LEDS);
    else if (sel_ctrl) rd_data = ctrl_rd;
    else if (sel_cmp)  rd_data = cmp;
    else if (sel_cnt)  rd_data = cnt;
    else if (sel_stat) rd_data = 32'(pend) << STAT_PEND;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS  <= '0;
      ctrl  <= '0;
      cmp   <= 32'hFFFF_FFFF;
      rd_q  <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      if (we_led) LEDS <= bus.IOBUS_OUT[LED_WIDTH-1:0];
      // CPU write to CTRL overrides the one-shot enable clear on the same edge.
      if (we_ctrl)     ctrl    <= timer_ctrl_t'(bus.IOBUS_OUT[2:0]);
      else if (en_clr) ctrl.en <= 1'b0;
      if (we_cmp) cmp <= bus.IOBUS_OUT;
      rd_q  <= rd_data;
      sw_s1 <= SWITCHES;
      sw_s2 <= sw_s1;
    end
  end

  assign bus.IOBUS_IN = rd_q;
  assign INTR         = pend & ctrl.ie;

endmodule

// File: tb/tb_iobus_responder.sv
// tb/tb_iobus_responder.sv - self-checking bench for iobus_responder with a read-data scoreboard
module tb_iobus_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        INTR;
  logic [15:0] SWITCHES = 16'h0000;
  logic [15:0] LEDS;

  iobus_responder_if bus();

  iobus_responder #(
    .BASE_ADDR(BASE), .SW_WIDTH(16), .LED_WIDTH(16), .PRESCALE(1)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus),
    .INTR     (INTR),
    .SWITCHES (SWITCHES),
    .LEDS     (LEDS)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic        rd_go = 1'b0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  // Scoreboard: each read issued before an edge is compared one edge later.
  always @(posedge CLK) begin
    if (rd_go) begin
      logic [31:0] e;
      string       n;
      #1;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      total++;
      if (bus.IOBUS_IN !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", n, bus.IOBUS_IN, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_OUT  = data;
    bus.IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    bus.IOBUS_WR = 1'b0;
  endtask

  task automatic issue_read(input logic [7:0] off, input logic [31:0] exp, input string nm);
    bus.IOBUS_ADDR = BASE + 32'(off);
    bus.IOBUS_WR   = 1'b0;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    rd_go = 1'b1;
    @(posedge CLK);
    #1;
    rd_go = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    total++;
    if (LEDS !== 16'h0) begin bad++; $display("FAIL reset_leds: got %h want 0000", LEDS); end
    total++;
    if (INTR !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", INTR); end
    total++;
    if (bus.IOBUS_IN !== 32'h0) begin bad++; $display("FAIL reset_iobus_in: got %h want 0", bus.IOBUS_IN); end
    issue_read(8'h44, 32'hFFFF_FFFF, "reset_cmp");
    issue_read(8'h40, 32'h0, "reset_ctrl");
    issue_read(8'h48, 32'h0, "reset_cnt");
    issue_read(8'h4C, 32'h0, "reset_stat");
  endtask

  task automatic test_led;
    bus_write(BASE + 32'h20, 32'hFFFF_A5A5);
    total++;
    if (LEDS !== 16'hA5A5) begin bad++; $display("FAIL led_out: got %h want a5a5", LEDS); end
    issue_read(8'h20, 32'h0000_A5A5, "led_read");
    bus_write(BASE + 32'h24, 32'h1234_5678);
    bus_write(BASE + 32'h120, 32'h0000_FFFF);
    total++;
    if (LEDS !== 16'hA5A5) begin bad++; $display("FAIL led_after_unmapped: got %h want a5a5", LEDS); end
    issue_read(8'h24, 32'h0, "unmapped_read");
    issue_read(8'h44, 32'hFFFF_FFFF, "cmp_untouched");
    issue_read(8'h40, 32'h0, "ctrl_untouched");
    issue_read(8'h23, 32'h0000_A5A5, "led_unaligned");
  endtask

  task automatic test_switches;
    #2;
    SWITCHES = 16'h1234;
    issue_read(8'h00, 32'h0, "sw_sync_1");
    issue_read(8'h00, 32'h0, "sw_sync_2");
    issue_read(8'h00, 32'h0000_1234, "sw_sync_3");
  endtask

  task automatic test_oneshot;
    bus_write(BASE + 32'h44, 32'd5);
    bus_write(BASE + 32'h40, 32'b101);
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      total++;
      if (INTR !== (i == 6)) begin
        bad++;
        $display("FAIL oneshot_intr_cycle%0d: got %b want %b", i, INTR, (i == 6));
      end
    end
    issue_read(8'h48, 32'd5, "oneshot_cnt_hold");
    issue_read(8'h40, 32'b100, "oneshot_en_clear");
    issue_read(8'h4C, 32'h1, "oneshot_stat");
    bus_write(BASE + 32'h4C, 32'h0);
    total++;
    if (INTR !== 1'b1) begin bad++; $display("FAIL w1c_zero_noeffect: got %b want 1", INTR); end
    bus_write(BASE + 32'h4C, 32'h1);
    total++;
    if (INTR !== 1'b0) begin bad++; $display("FAIL w1c_clear: got %b want 0", INTR); end
  endtask

  task automatic test_autoreload;
    logic [31:0] model_cnt;
    bus_write(BASE + 32'h48, 32'd0);
    bus_write(BASE + 32'h44, 32'd3);
    bus_write(BASE + 32'h40, 32'b111);
    model_cnt = 32'd0;
    for (int k = 1; k <= 7; k++) begin
      issue_read(8'h48, model_cnt, $sformatf("reload_cnt_%0d", k));
      model_cnt = (model_cnt == 32'd3) ? 32'd0 : model_cnt + 32'd1;
    end
    total++;
    if (INTR !== 1'b1) begin bad++; $display("FAIL reload_pend: got %b want 1", INTR); end
    bus_write(BASE + 32'h4C, 32'h1);
    total++;
    if (INTR !== 1'b1) begin bad++; $display("FAIL w1c_on_match: got %b want 1", INTR); end
    bus_write(BASE + 32'h4C, 32'h1);
    total++;
    if (INTR !== 1'b0) begin bad++; $display("FAIL w1c_after_match: got %b want 0", INTR); end
    issue_read(8'h48, 32'd1, "reload_cnt_after");
  endtask

  task automatic test_reset_mid_count;
    bus_write(BASE + 32'h48, 32'd0);
    bus_write(BASE + 32'h44, 32'd3);
    bus_write(BASE + 32'h40, 32'b111);
    idle(6);
    total++;
    if (INTR !== 1'b1) begin bad++; $display("FAIL pre_reset_intr: got %b want 1", INTR); end
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    total++;
    if (INTR !== 1'b0) begin bad++; $display("FAIL midreset_intr: got %b want 0", INTR); end
    total++;
    if (LEDS !== 16'h0) begin bad++; $display("FAIL midreset_leds: got %h want 0000", LEDS); end
    issue_read(8'h48, 32'd0, "midreset_cnt");
    issue_read(8'h40, 32'd0, "midreset_ctrl");
    idle(4);
    issue_read(8'h48, 32'd0, "midreset_cnt_stays");
    issue_read(8'h44, 32'hFFFF_FFFF, "midreset_cmp");
  endtask

  initial begin
    bus.IOBUS_ADDR = BASE;
    bus.IOBUS_OUT  = 32'h0;
    bus.IOBUS_WR   = 1'b0;
    idle(2);
    test_reset;
    test_led;
    test_switches;
    test_oneshot;
    test_autoreload;
    test_reset_mid_count;
    idle(2);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
